// File: rtl/mul_pkg.sv
// Shared types and defaults for the repeated-addition multiplier.
package mul_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CHECK,
    S_ADD,
    S_DONE
  } state_t;

endpackage

// File: rtl/mul_repadd_ctrl.sv
// Sequencer for the repeated-addition multiplier: walks the operand load,
// zero check and add loop, and issues datapath strobes.
module mul_repadd_ctrl
  import mul_pkg::*;
#(
  parameter bit SWAP_MIN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic eqz,
  input  logic last,
  input  logic cnt_gt_x,
  output logic ld_a_c,
  output logic ld_b_c,
  output logic clr_p_c,
  output logic ld_p_c,
  output logic dec_b_c,
  output logic swap_c,
  output logic busy,
  output logic done
);

  state_t state;
  logic   abort_c;

  assign abort_c = abort && (state != S_IDLE);

  // Abort outranks every transition; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort_c) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD_A;
          else       busy  <= 1'b0;
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: state <= S_CHECK;
        S_CHECK: begin
          if (eqz) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ADD;
          end
        end
        S_ADD: begin
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes act on the same edge as the state change they accompany.
  always_comb begin
    ld_a_c  = 1'b0;
    ld_b_c  = 1'b0;
    clr_p_c = abort_c;
    ld_p_c  = 1'b0;
    dec_b_c = 1'b0;
    swap_c  = 1'b0;
    if (!abort_c) begin
      case (state)
        S_LOAD_A: ld_a_c = 1'b1;
        S_LOAD_B: begin
          ld_b_c  = 1'b1;
          clr_p_c = 1'b1;
        end
        S_CHECK:  swap_c = SWAP_MIN && cnt_gt_x;
        S_ADD: begin
          ld_p_c  = 1'b1;
          dec_b_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mul_repadd_param.sv
// Unsigned multiplier by repeated addition; operand, count and product
// registers plus the adder live here, sequencing lives in mul_repadd_ctrl.
module mul_repadd_param
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter bit          SWAP_MIN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   data_in,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] cnt_q;
  logic [PW-1:0]    p_q;

  logic ld_a_c, ld_b_c, clr_p_c, ld_p_c, dec_b_c, swap_c;
  logic eqz_c, last_c, cnt_gt_x_c;

  assign eqz_c      = (x_q == '0) || (cnt_q == '0);
  assign last_c     = (cnt_q == WIDTH'(1));
  assign cnt_gt_x_c = (cnt_q > x_q);

  mul_repadd_ctrl #(
    .SWAP_MIN (SWAP_MIN)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .eqz      (eqz_c),
    .last     (last_c),
    .cnt_gt_x (cnt_gt_x_c),
    .ld_a_c   (ld_a_c),
    .ld_b_c   (ld_b_c),
    .clr_p_c  (clr_p_c),
    .ld_p_c   (ld_p_c),
    .dec_b_c  (dec_b_c),
    .swap_c   (swap_c),
    .busy     (busy),
    .done     (done)
  );

  // Operand and count registers; swap makes the smaller operand the loop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (ld_a_c) x_q <= data_in;
      if (ld_b_c) cnt_q <= data_in;
      if (swap_c) begin
        x_q   <= cnt_q;
        cnt_q <= x_q;
      end
      if (dec_b_c) cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  // Accumulator; clear wins so an abort mid-add leaves zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (clr_p_c) begin
      p_q <= '0;
    end else if (ld_p_c) begin
      p_q <= p_q + PW'(x_q);
    end
  end

  assign product = p_q;

endmodule

// File: tb/tb_mul_repadd_param.sv
// Scoreboard bench for mul_repadd_param: three instances cover the default,
// no-swap and 8-bit configurations.
module tb_mul_repadd_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [15:0] din [3];
  logic [31:0] p0, p1;
  logic [15:0] p2;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [31:0] prod [3];

  always #5 clk = ~clk;

  assign prod[0] = p0;
  assign prod[1] = p1;
  assign prod[2] = 32'(p2);

  mul_repadd_param #(.WIDTH(16), .SWAP_MIN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .data_in(din[0]), .product(p0), .busy(busy[0]), .done(done[0]));

  mul_repadd_param #(.WIDTH(16), .SWAP_MIN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .data_in(din[1]), .product(p1), .busy(busy[1]), .done(done[1]));

  mul_repadd_param #(.WIDTH(8), .SWAP_MIN(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .data_in(din[2][7:0]), .product(p2), .busy(busy[2]), .done(done[2]));

  typedef struct {
    int unsigned dut;
    logic [31:0] prod;
    int unsigned lat;
  } exp_t;

  exp_t        sbq [$];
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_done u%0d: got done=1 expected no done", i);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check($sformatf("done_dut u%0d", i), 32'(i), 32'(e.dut));
          check($sformatf("product u%0d", i), prod[i], e.prod);
          check($sformatf("latency u%0d", i), 32'(cyc - start_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic run(input int d, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp_prod, input int unsigned lat);
    exp_t e;
    logic busy_bad;
    busy_bad = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    e.dut = d; e.prod = exp_prod; e.lat = lat;
    sbq.push_back(e);
    @(negedge clk);
    start[d] = 1'b0;
    din[d] = a;
    @(negedge clk);
    din[d] = b;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
      if (busy[d] !== 1'b1) busy_bad = 1'b1;
    end
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout u%0d: got no done expected done for %0d x %0d", d, a, b);
      sbq.delete();
    end
    check($sformatf("busy_throughout u%0d", d), 32'(busy_bad), 32'd0);
    repeat (3) @(negedge clk);
    check($sformatf("product_hold u%0d", d), prod[d], exp_prod);
    check($sformatf("idle_busy u%0d", d), 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_product u%0d", i), prod[i], 32'd0);
      check($sformatf("reset_busy u%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("reset_done u%0d", i), 32'(done[i]), 32'd0);
    end
    rst_n = 1'b1;

    run(0, 16'd6, 16'd5, 32'd30, 9);
    run(0, 16'd0, 16'd7, 32'd0, 4);
    run(0, 16'd7, 16'd0, 32'd0, 4);
    run(0, 16'd3, 16'd200, 32'd600, 7);
    run(1, 16'd3, 16'd200, 32'd600, 204);
    run(1, 16'd200, 16'd3, 32'd600, 7);
    run(2, 16'd255, 16'd255, 32'd65025, 259);
    run(0, 16'd65535, 16'd2, 32'd131070, 6);

    // Abort during the third ADD of 6x5, with a start pulse while busy.
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[0] = 1'b0; din[0] = 16'd6;
    @(negedge clk); din[0] = 16'd5;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk);
    check("abort_pre_product", prod[0], 32'd6);
    @(negedge clk); abort[0] = 1'b1;
    @(negedge clk); abort[0] = 1'b0;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_product", prod[0], 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    repeat (6) @(negedge clk);
    check("abort_stays_idle", 32'(busy[0]), 32'd0);
    check("abort_product_held", prod[0], 32'd0);

    // Abort while idle does nothing.
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("idle_abort_busy", 32'(busy[0]), 32'd0);

    // Reset pulled mid-ADD, then a fresh 4x4.
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[0] = 1'b0; din[0] = 16'd6;
    @(negedge clk); din[0] = 16'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_product", prod[0], 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 16'd4, 16'd4, 32'd16, 8);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
